spi_minion_frontend: RTL
========================

# spi_minion_frontend

Pin-side SPI minion stage that sits directly upstream of the FFT/SPI interconnect: it samples the raw `minion_cs`/`minion_sclk`/`minion_mosi` pads in the system clock domain and turns fixed-length SPI frames into a val/rdy message stream toward the design. It also carries a return stream from the design back out on MISO. Flow-control bits in every frame let the host know whether the minion has space and whether return data is valid, so no message is ever dropped.

## Interface
- `N`, 32, payload width; frame length is N+2 bits.
- `DEPTH`, 2, entries in the host-to-design receive queue; must be ≥1.

- `clk`  in  1  system clock; all logic is single-clock.
- `reset`  in  1  synchronous, active-high reset.
- `minion_cs`  in  1  async pad, active-low chip select.
- `minion_sclk`  in  1  async pad, SPI clock (mode 0).
- `minion_mosi`  in  1  async pad, host-to-minion data, MSB first.
- `minion_miso`  out  1  minion-to-host data, MSB first.
- `send_msg`  out  N  payload from host, toward design.
- `send_val`  out  1  receive queue non-empty.
- `send_rdy`  in  1  design accepts `send_msg`.
- `recv_msg`  in  N  payload from design, toward host.
- `recv_val`  in  1  design offers `recv_msg`.
- `recv_rdy`  out  1  TX holding register empty.
- `minion_parity`  out  1  XOR-reduce of the most recently enqueued payload.

## Operation
- **Sync:** each pad passes through 2 flops and a third flop for edge detection, giving synced level plus rise/fall pulses.
- **MOSI frame:** bit N+1 = `wr` (host is writing a payload); bit N = `rd` (host is consuming the returned payload); bits N-1:0 = payload.
- **MISO frame:** bit N+1 = `spc` (receive queue had space at frame start); bit N = `tval` (TX register was full at frame start); bits N-1:0 = TX payload, or 0 when `tval`=0.
- **States:**
  - `IDLE`: on cs fall, snapshot `spc`/`tval`/payload into the TX shift register, drive bit N+1 on MISO, clear the bit counter, go to `SHIFT`.
  - `SHIFT`: on sclk rise, shift in MOSI and increment the counter. On sclk fall, shift out the next MISO bit. On cs rise, go to `DONE`.
  - `DONE`: lasts one cycle, then returns to `IDLE`.
    - If the counter ≠ N+2, the frame is discarded: no enqueue, no dequeue.
    - Else if `wr`=1 and `spc`=1, enqueue the payload and update `minion_parity`.
    - Else if `wr`=1 and `spc`=0, drop the payload silently (host protocol violation).
    - Independently, if `rd`=1 and `tval`=1, clear the TX register.
- **Counter:** saturates at N+3; never wraps.
- **Receive queue:** `DEPTH`-entry FIFO.
  - Simultaneous enqueue and dequeue when full is legal only if `spc` was sampled as 1; dequeue during a frame never invalidates `spc`.
- **TX register:** loads on `recv_val && recv_rdy`.
  - A load during `SHIFT` when the register was empty at frame start is held for the next frame and must not be cleared by this frame's `rd`.
- **Reset:** FSM → `IDLE`, queue empty, TX empty, counter 0.
  - If cs is low when reset deasserts, wait for cs high, then cs low, before starting a frame.

## Timing
- **Reset values:**
  - `minion_miso`=0, `send_val`=0, `minion_parity`=0.
  - `recv_rdy`=0 while `reset`=1, and 1 on the first cycle after reset.
- **Pad-to-edge-pulse latency:** 3 cycles. sclk high and low phases must each be ≥4 `clk` cycles.
- **MISO timing:**
  - Bit N+1 is valid ≤4 cycles after the cs fall edge at the pad.
  - Each later bit is valid ≤4 cycles after the sclk fall at the pad.
- **Enqueue latency:** enqueue occurs in `DONE`; `send_val` rises the next cycle (5 cycles after the cs rise at the pad). `minion_parity` updates in the same cycle as `send_val`.
- **TX handshake:** `recv_rdy` falls the cycle after an accepted load and rises the cycle after `DONE` clears the register.

## Structure
- **Package `spi_minion_pkg`:**
  - frame-width function N+2;
  - bit-index constants `WR_BIT`/`RD_BIT` (MOSI) and `SPC_BIT`/`TVAL_BIT` (MISO);
  - FSM state enum `IDLE`/`SHIFT`/`DONE`.
- **Sub-module `spi_pin_sync`:** 2-flop synchronizer plus edge detector with outputs `level`, `rise`, `fall`. Instantiated 3×.
- Receive queue uses the team's existing val/rdy FIFO.

## Test plan
- Reset, then one frame with `wr`=1 and payload 0xDEADBEEF → `send_msg`=0xDEADBEEF, `send_val`=1 five cycles after cs rises, `minion_parity`=0 (24 ones); host saw `spc`=1, `tval`=0.
- Hold `send_rdy`=0 and write 3 frames with DEPTH=2 → frames 1–2 see `spc`=1, frame 3 sees `spc`=0 and its payload is dropped; then drain and get exactly 2 messages in order.
- `recv_msg`=0x12345678 accepted, then a frame with `rd`=1 → MISO returns `tval`=1 and 0x12345678; `recv_rdy` returns to 1 after `DONE`; next frame shows `tval`=0 with payload 0.
- Frame aborted after 20 sclk edges with `wr`=1 and `rd`=1 → no enqueue, TX register kept, `recv_rdy` stays 0.
- Assert `reset` mid-frame with cs held low, then finish clocking → nothing enqueued; the next full frame after cs high→low is received correctly.
- Load `recv_msg` during a frame started with TX empty and `rd`=1 → the loaded value survives and appears on the following frame.

Source files
------------

// File: rtl/spi_minion_pkg.sv
// Shared constants, frame-width helper and FSM state type for the SPI minion front end.
package spi_minion_pkg;

    // Header bit positions counted above the N-bit payload (absolute index = N + *_BIT).
    localparam int unsigned WR_BIT   = 1;
    localparam int unsigned RD_BIT   = 0;
    localparam int unsigned SPC_BIT  = 1;
    localparam int unsigned TVAL_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int unsigned frame_w(input int unsigned n);
        return n + 2;
    endfunction

endpackage

// File: rtl/spi_minion_frontend_pin_sync.sv
// Two-flop pad synchronizer with a third flop for edge detection; pulses are registered so
// level, rise and fall all describe the same pad sample.
module spi_pin_sync (
    input  logic clk,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        s1_q   <= pad;
        s2_q   <= s1_q;
        s3_q   <= s2_q;
        rise_q <= s2_q & ~s3_q;
        fall_q <= ~s2_q & s3_q;
    end

    assign level = s3_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_minion_frontend.sv
// SPI minion front end: turns fixed-length SPI frames into a val/rdy message stream and
// returns a design payload on MISO, with per-frame flow-control header bits.
module spi_minion_frontend
    import spi_minion_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         minion_cs,
    input  logic         minion_sclk,
    input  logic         minion_mosi,
    output logic         minion_miso,
    output logic [N-1:0] send_msg,
    output logic         send_val,
    input  logic         send_rdy,
    input  logic [N-1:0] recv_msg,
    input  logic         recv_val,
    output logic         recv_rdy,
    output logic         minion_parity
);

    localparam int unsigned FW = frame_w(N);
    localparam int unsigned CW = $clog2(FW + 2);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned QW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(FW);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_pin_sync u_sync_cs (
        .clk   (clk),
        .pad   (minion_cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    spi_pin_sync u_sync_sclk (
        .clk   (clk),
        .pad   (minion_sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_pin_sync u_sync_mosi (
        .clk   (clk),
        .pad   (minion_mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          miso_q;
    logic          armed_q;
    logic          spc_q;
    logic          tval_q;
    logic          tx_full_q;
    logic          parity_q;
    logic [N-1:0]  tx_data_q;
    logic [FW-2:0] tx_sh_q;
    logic [FW-1:0] rx_q;
    logic [FW-1:0] tx_frame;

    logic [N-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [QW-1:0] count_q;

    logic space;
    logic start;
    logic shift_in;
    logic shift_out;
    logic frame_ok;
    logic enq;
    logic deq;
    logic tx_load;
    logic tx_clr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign space     = (count_q < QW'(DEPTH));
    assign send_val  = (count_q != '0);
    assign send_msg  = mem_q[rd_ptr_q];
    assign deq       = send_val & send_rdy;
    assign recv_rdy  = ~tx_full_q & ~reset;
    assign tx_load   = recv_val & recv_rdy;

    // armed_q blocks a frame that was already in flight when reset released.
    assign start     = (state_q == IDLE) && cs_fall && armed_q;
    assign shift_in  = (state_q == SHIFT) && sclk_rise;
    assign shift_out = (state_q == SHIFT) && sclk_fall;
    assign frame_ok  = (state_q == DONE) && (cnt_q == CNT_FULL);
    assign enq       = frame_ok && rx_q[N + WR_BIT] && spc_q;
    assign tx_clr    = frame_ok && rx_q[N + RD_BIT] && tval_q;

    assign minion_miso   = miso_q;
    assign minion_parity = parity_q;

    always_comb begin
        tx_frame                = '0;
        tx_frame[N + SPC_BIT]   = space;
        tx_frame[N + TVAL_BIT]  = tx_full_q;
        if (tx_full_q) begin
            tx_frame[N-1:0] = tx_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            miso_q    <= 1'b0;
            armed_q   <= 1'b0;
            spc_q     <= 1'b0;
            tval_q    <= 1'b0;
            tx_full_q <= 1'b0;
            parity_q  <= 1'b0;
        end else begin
            if (cs_level) begin
                armed_q <= 1'b1;
            end
            if (tx_clr) begin
                tx_full_q <= 1'b0;
            end else if (tx_load) begin
                tx_full_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        spc_q   <= space;
                        tval_q  <= tx_full_q;
                        miso_q  <= tx_frame[FW-1];
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_in && (cnt_q != CNT_SAT)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    if (shift_out) begin
                        miso_q <= tx_sh_q[FW-2];
                    end
                    if (cs_rise) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    miso_q  <= 1'b0;
                    state_q <= IDLE;
                    if (enq) begin
                        parity_q <= ^rx_q[N-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Receive queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            unique case ({enq, deq})
                2'b10:   count_q <= count_q + QW'(1);
                2'b01:   count_q <= count_q - QW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            tx_sh_q <= tx_frame[FW-2:0];
        end else if (shift_out) begin
            tx_sh_q <= {tx_sh_q[FW-3:0], 1'b0};
        end
        if (shift_in) begin
            rx_q <= {rx_q[FW-2:0], mosi_level};
        end
        if (tx_load) begin
            tx_data_q <= recv_msg;
        end
        if (enq) begin
            mem_q[wr_ptr_q] <= rx_q[N-1:0];
        end
    end

endmodule
